// File: rtl/cic_agc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cic_pkg
// Brief   : Shared types, default widths and magnitude helper for the CIC AGC.
// Revision: 1.0 - initial release
// ============================================================================
package cic_pkg;

    localparam int DEF_SAMPLE_W = 12;
    localparam int DEF_GAIN_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_ADJUST  = 2'd2,
        ST_SETTLE  = 2'd3
    } agc_state_t;

    // |x| of a w-bit signed value (sign-extended to 32 bits); the most
    // negative code saturates to the most positive one instead of wrapping.
    function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int w);
        logic signed [31:0] v_min;
        v_min = -(32'sd1 <<< (w - 1));
        if (x == v_min) begin
            return (32'd1 << (w - 1)) - 32'd1;
        end
        if (x < 0) begin
            return 32'(-x);
        end
        return 32'(x);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_agc_ctrl_peak_detector.sv
`default_nettype none
// ============================================================================
// Module  : cic_peak_detector
// Brief   : Windowed peak-magnitude tracker with clip detect for the CIC AGC.
// Revision: 1.0 - initial release
// ============================================================================
module cic_peak_detector
    import cic_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int WINDOW   = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       strobe,
    input  logic signed [SAMPLE_W-1:0] samp_in,
    input  logic                       clear,
    output logic        [SAMPLE_W-1:0] peak,
    output logic                       clip,
    output logic                       win_done
);

    localparam int CNT_W = $clog2(WINDOW);
    localparam logic signed [SAMPLE_W-1:0] C_POS_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] C_NEG_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic        [CNT_W-1:0]    C_WIN_LAST = CNT_W'(WINDOW - 1);

    logic [CNT_W-1:0]    r_win_cnt;
    logic [SAMPLE_W-1:0] r_peak;
    logic [SAMPLE_W-1:0] w_mag;

    assign w_mag    = SAMPLE_W'(sat_abs(32'(samp_in), SAMPLE_W));
    assign clip     = strobe & ((samp_in == C_POS_MAX) | (samp_in == C_NEG_MIN));
    assign win_done = strobe & (r_win_cnt == C_WIN_LAST);
    assign peak     = r_peak;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt <= '0;
            r_peak    <= '0;
        end else if (clear) begin
            r_win_cnt <= '0;
            r_peak    <= '0;
        end else if (strobe) begin
            r_win_cnt <= r_win_cnt + CNT_W'(1);
            if (w_mag > r_peak) begin
                r_peak <= w_mag;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cic_agc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cic_agc_ctrl
// Brief   : Peak-tracking automatic gain control driving the CIC Gain input.
// Revision: 1.0 - initial release
// ============================================================================
module cic_agc_ctrl
    import cic_pkg::*;
#(
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter int GAIN_W    = DEF_GAIN_W,
    parameter int WINDOW    = 256,
    parameter int HI_THRESH = 1536,
    parameter int LO_THRESH = 512,
    parameter int GAIN_MIN  = 0,
    parameter int GAIN_MAX  = 20,
    parameter int GAIN_INIT = 8,
    parameter int SETTLE    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       manual_mode,
    input  logic        [GAIN_W-1:0]   manual_gain,
    input  logic signed [SAMPLE_W-1:0] samp_in,
    input  logic                       samp_clk,
    output logic        [GAIN_W-1:0]   gain_out,
    output logic                       gain_step,
    output logic                       clip_flag,
    output logic        [1:0]          state_dbg
);

    localparam int SCNT_W = $clog2(SETTLE + 1);
    localparam logic [GAIN_W-1:0]   C_GAIN_MIN    = GAIN_W'(GAIN_MIN);
    localparam logic [GAIN_W-1:0]   C_GAIN_MAX    = GAIN_W'(GAIN_MAX);
    localparam logic [GAIN_W-1:0]   C_GAIN_INIT   = GAIN_W'(GAIN_INIT);
    localparam logic [SAMPLE_W-1:0] C_HI          = SAMPLE_W'(HI_THRESH);
    localparam logic [SAMPLE_W-1:0] C_LO          = SAMPLE_W'(LO_THRESH);
    localparam logic [SCNT_W-1:0]   C_SETTLE_LAST = SCNT_W'(SETTLE - 1);

    agc_state_t          r_state;
    agc_state_t          w_next;
    logic                r_samp_clk_q;
    logic                r_manual_q;
    logic                r_clip_pend;
    logic                r_clip_flag;
    logic                r_gain_step;
    logic [GAIN_W-1:0]   r_gain;
    logic [GAIN_W-1:0]   w_man_gain;
    logic [SCNT_W-1:0]   r_settle_cnt;
    logic [SAMPLE_W-1:0] w_peak;
    logic                w_strobe;
    logic                w_manual_fall;
    logic                w_run;
    logic                w_meas_strobe;
    logic                w_clear;
    logic                w_clip;
    logic                w_win_done;
    logic                w_win_start;
    logic                w_dec;
    logic                w_inc;
    logic                w_change;

    // The edge register resets high so a samp_clk held high through reset
    // is not mistaken for a new sample on release.
    assign w_strobe      = samp_clk & ~r_samp_clk_q;
    assign w_manual_fall = r_manual_q & ~manual_mode;
    assign w_run         = enable & ~manual_mode;
    assign w_win_start   = (w_next == ST_MEASURE) && (r_state != ST_MEASURE);

    cic_peak_detector #(
        .SAMPLE_W (SAMPLE_W),
        .WINDOW   (WINDOW)
    ) u_peak (
        .clk      (clk),
        .rst_n    (rst_n),
        .strobe   (w_meas_strobe),
        .samp_in  (samp_in),
        .clear    (w_clear),
        .peak     (w_peak),
        .clip     (w_clip),
        .win_done (w_win_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!w_run) begin
            w_next = ST_IDLE;
        end else if (w_manual_fall) begin
            w_next = ST_SETTLE;
        end else begin
            case (r_state)
                ST_IDLE:    w_next = ST_MEASURE;
                ST_MEASURE: begin
                    if ((w_clip && (r_gain > C_GAIN_MIN)) || w_win_done) begin
                        w_next = ST_ADJUST;
                    end
                end
                ST_ADJUST:  w_next = w_change ? ST_SETTLE : ST_MEASURE;
                ST_SETTLE: begin
                    if (w_strobe && (r_settle_cnt == C_SETTLE_LAST)) begin
                        w_next = ST_MEASURE;
                    end
                end
                default:    w_next = ST_IDLE;
            endcase
        end
    end

    // Outside MEASURE the peak detector is held cleared, so every entry to
    // MEASURE starts a fresh window.
    always_comb begin
        w_meas_strobe = 1'b0;
        w_clear       = 1'b1;
        w_dec         = 1'b0;
        w_inc         = 1'b0;
        case (r_state)
            ST_MEASURE: begin
                w_clear       = 1'b0;
                w_meas_strobe = w_strobe & w_run;
            end
            ST_ADJUST: begin
                if (w_run) begin
                    if ((r_clip_pend || (w_peak >= C_HI)) && (r_gain > C_GAIN_MIN)) begin
                        w_dec = 1'b1;
                    end else if ((w_peak < C_LO) && (r_gain < C_GAIN_MAX)) begin
                        w_inc = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        w_change = w_dec | w_inc;
    end

    always_comb begin
        w_man_gain = manual_gain;
        if (int'(manual_gain) < GAIN_MIN) begin
            w_man_gain = C_GAIN_MIN;
        end else if (int'(manual_gain) > GAIN_MAX) begin
            w_man_gain = C_GAIN_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp_clk_q <= 1'b1;
            r_manual_q   <= 1'b0;
            r_clip_pend  <= 1'b0;
            r_clip_flag  <= 1'b0;
            r_settle_cnt <= '0;
        end else begin
            r_samp_clk_q <= samp_clk;
            r_manual_q   <= manual_mode;
            r_clip_pend  <= w_clip;
            if (w_win_start) begin
                r_clip_flag <= 1'b0;
            end else if (w_clip) begin
                r_clip_flag <= 1'b1;
            end
            if (r_state != ST_SETTLE) begin
                r_settle_cnt <= '0;
            end else if (w_strobe) begin
                r_settle_cnt <= r_settle_cnt + SCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gain      <= C_GAIN_INIT;
            r_gain_step <= 1'b0;
        end else if (manual_mode) begin
            r_gain      <= w_man_gain;
            r_gain_step <= (w_man_gain != r_gain);
        end else if (w_dec) begin
            r_gain      <= r_gain - GAIN_W'(1);
            r_gain_step <= 1'b1;
        end else if (w_inc) begin
            r_gain      <= r_gain + GAIN_W'(1);
            r_gain_step <= 1'b1;
        end else begin
            r_gain_step <= 1'b0;
        end
    end

    assign gain_out  = r_gain;
    assign gain_step = r_gain_step;
    assign clip_flag = r_clip_flag;
    assign state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_cic_agc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cic_agc_ctrl
// Brief   : Self-checking bench for cic_agc_ctrl (vector table + random model).
// Revision: 1.0 - initial release
// ============================================================================
module tb_cic_agc_ctrl;

    localparam int WIN      = 256;
    localparam int HI       = 1536;
    localparam int LO       = 512;
    localparam int GMIN     = 0;
    localparam int GMAX     = 20;
    localparam int GINIT    = 8;
    localparam int SETTLE_N = 8;
    localparam int S_IDLE = 0, S_MEAS = 1, S_ADJ = 2, S_SET = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic               manual_mode;
    logic        [7:0]  manual_gain;
    logic signed [11:0] samp_in;
    logic               samp_clk;
    logic        [7:0]  gain_out;
    logic               gain_step;
    logic               clip_flag;
    logic        [1:0]  state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int step_cnt = 0;
    int s0;
    int m_gain, m_settle, m_peak, m_n, m_steps;

    typedef struct {
        int start_gain;
        int amp;
        int exp_gain;
        int exp_steps;
    } vec_t;
    vec_t vecs[12];

    cic_agc_ctrl #(
        .SAMPLE_W (12), .GAIN_W (8), .WINDOW (WIN), .HI_THRESH (HI),
        .LO_THRESH (LO), .GAIN_MIN (GMIN), .GAIN_MAX (GMAX),
        .GAIN_INIT (GINIT), .SETTLE (SETTLE_N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .manual_mode (manual_mode),
        .manual_gain (manual_gain),
        .samp_in     (samp_in),
        .samp_clk    (samp_clk),
        .gain_out    (gain_out),
        .gain_step   (gain_step),
        .clip_flag   (clip_flag),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (gain_step === 1'b1) step_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_sample(input int v);
        samp_in  = 12'(v);
        samp_clk = 1'b1;
        tick(1);
        samp_clk = 1'b0;
        tick(1);
    endtask

    // Force a gain through manual mode, then release and let SETTLE finish.
    task automatic set_gain(input int g);
        manual_gain = 8'(g);
        manual_mode = 1'b1;
        tick(2);
        manual_mode = 1'b0;
        tick(1);
        check("set_gain_settle", int'(state_dbg), S_SET);
        repeat (SETTLE_N) send_sample(0);
        check("set_gain_measure", int'(state_dbg), S_MEAS);
        check("set_gain_value", int'(gain_out), g);
        m_gain = g; m_settle = 0; m_peak = 0; m_n = 0;
    endtask

    // One full window whose largest magnitude is exactly amp (never a clip code).
    task automatic run_window(input int amp);
        int idx, mag, v;
        idx = $urandom_range(0, WIN - 1);
        for (int i = 0; i < WIN; i++) begin
            if (i == idx) v = -amp;
            else begin
                mag = $urandom_range(0, amp - 1);
                v = ($urandom_range(0, 1) != 0) ? mag : -mag;
            end
            send_sample(v);
        end
    endtask

    // Sample-level reference: windows of WIN samples, fast attack on clips,
    // SETTLE_N discarded samples after every gain change.
    task automatic model_sample(input int v);
        int mag;
        bit clipv;
        if (m_settle > 0) begin
            m_settle--;
            if (m_settle == 0) begin m_n = 0; m_peak = 0; end
            return;
        end
        clipv = (v == 2047) || (v == -2048);
        mag = (v == -2048) ? 2047 : ((v < 0) ? -v : v);
        if (mag > m_peak) m_peak = mag;
        m_n++;
        if (clipv && m_gain > GMIN) begin
            m_gain--; m_steps++; m_settle = SETTLE_N;
        end else if (m_n == WIN) begin
            if (m_peak >= HI && m_gain > GMIN) begin
                m_gain--; m_steps++; m_settle = SETTLE_N;
            end else if (m_peak < LO && m_gain < GMAX) begin
                m_gain++; m_steps++; m_settle = SETTLE_N;
            end else begin
                m_n = 0; m_peak = 0;
            end
        end
    endtask

    initial begin
        int lvl, maxmag, v, mag;
        rst_n = 1'b1; enable = 1'b0; manual_mode = 1'b0; manual_gain = '0;
        samp_in = '0; samp_clk = 1'b0;
        #2 rst_n = 1'b0;
        tick(3);
        check("reset_gain", int'(gain_out), GINIT);
        check("reset_state", int'(state_dbg), S_IDLE);
        check("reset_step", int'(gain_step), 0);
        check("reset_clip", int'(clip_flag), 0);
        rst_n = 1'b1; enable = 1'b1;
        tick(2);
        check("enter_measure", int'(state_dbg), S_MEAS);
        check("no_strobe_gain", int'(gain_out), GINIT);

        // Fast attack on a clip at strobe 10, then a clip inside SETTLE.
        set_gain(8);
        repeat (9) send_sample(50);
        s0 = step_cnt;
        samp_in = -12'sd2048; samp_clk = 1'b1;
        tick(1);
        check("clip_adjust_state", int'(state_dbg), S_ADJ);
        check("clip_flag_set", int'(clip_flag), 1);
        check("clip_gain_not_yet", int'(gain_out), 8);
        samp_clk = 1'b0;
        tick(1);
        check("clip_gain", int'(gain_out), 7);
        check("clip_settle_state", int'(state_dbg), S_SET);
        check("clip_steps", step_cnt - s0, 1);
        send_sample(-2048);
        check("settle_clip_gain", int'(gain_out), 7);
        check("settle_clip_state", int'(state_dbg), S_SET);
        check("settle_clip_steps", step_cnt - s0, 1);
        check("clip_flag_sticky", int'(clip_flag), 1);
        repeat (SETTLE_N - 1) send_sample(0);
        check("settle_done_state", int'(state_dbg), S_MEAS);
        check("clip_flag_cleared", int'(clip_flag), 0);

        // Window decisions at the thresholds and gain limits.
        vecs[0]  = '{8, 1600, 7, 1};
        vecs[1]  = '{8, 100, 9, 1};
        vecs[2]  = '{20, 100, 20, 0};
        vecs[3]  = '{8, 1000, 8, 0};
        vecs[4]  = '{0, 1600, 0, 0};
        vecs[5]  = '{8, 1536, 7, 1};
        vecs[6]  = '{8, 1535, 8, 0};
        vecs[7]  = '{8, 512, 8, 0};
        vecs[8]  = '{8, 511, 9, 1};
        vecs[9]  = '{8, 2047, 7, 1};
        vecs[10] = '{19, 100, 20, 1};
        vecs[11] = '{1, 1600, 0, 1};
        for (int i = 0; i < 12; i++) begin
            set_gain(vecs[i].start_gain);
            s0 = step_cnt;
            run_window(vecs[i].amp);
            check($sformatf("vec%0d_gain", i), int'(gain_out), vecs[i].exp_gain);
            check($sformatf("vec%0d_steps", i), step_cnt - s0, vecs[i].exp_steps);
            check($sformatf("vec%0d_state", i), int'(state_dbg),
                  (vecs[i].exp_steps != 0) ? S_SET : S_MEAS);
        end

        // Manual override with clamping, then release into SETTLE.
        s0 = step_cnt;
        manual_gain = 8'd50; manual_mode = 1'b1;
        tick(1);
        check("manual_clamp", int'(gain_out), GMAX);
        check("manual_idle", int'(state_dbg), S_IDLE);
        tick(1);
        check("manual_one_step", step_cnt - s0, 1);
        manual_gain = 8'd3;
        tick(1);
        check("manual_follow", int'(gain_out), 3);
        manual_gain = 8'd50;
        tick(2);
        manual_mode = 1'b0;
        tick(1);
        check("manual_release_state", int'(state_dbg), S_SET);
        check("manual_release_gain", int'(gain_out), GMAX);

        // enable=0 mid-window holds gain; re-enable starts a fresh window.
        set_gain(12);
        repeat (100) send_sample(80);
        enable = 1'b0;
        tick(1);
        check("disable_idle", int'(state_dbg), S_IDLE);
        send_sample(80);
        check("disable_hold_gain", int'(gain_out), 12);
        enable = 1'b1;
        tick(1);
        check("reenable_measure", int'(state_dbg), S_MEAS);
        s0 = step_cnt;
        repeat (WIN - 1) send_sample(80);
        check("reenable_partial_state", int'(state_dbg), S_MEAS);
        check("reenable_partial_gain", int'(gain_out), 12);
        send_sample(80);
        check("reenable_window_gain", int'(gain_out), 13);
        check("reenable_window_steps", step_cnt - s0, 1);

        // Randomized traffic against the reference model.
        set_gain(int'($urandom_range(GMIN, GMAX)));
        m_steps = 0;
        s0 = step_cnt;
        for (int b = 0; b < 8; b++) begin
            lvl = $urandom_range(0, 3);
            maxmag = (lvl == 0) ? 450 : (lvl == 1) ? 1300 : (lvl == 2) ? 2046 : 700;
            for (int k = 0; k < WIN; k++) begin
                if ($urandom_range(0, 199) == 0) begin
                    v = ($urandom_range(0, 1) != 0) ? 2047 : -2048;
                end else begin
                    mag = $urandom_range(0, maxmag);
                    v = ($urandom_range(0, 1) != 0) ? mag : -mag;
                end
                send_sample(v);
                model_sample(v);
                check("rand_gain", int'(gain_out), m_gain);
                check("rand_state", int'(state_dbg), (m_settle > 0) ? S_SET : S_MEAS);
            end
        end
        check("rand_steps", step_cnt - s0, m_steps);

        // Asynchronous reset mid-window with samp_clk held high across it.
        set_gain(15);
        repeat (100) send_sample(1600);
        samp_in = 12'sd1600; samp_clk = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_gain", int'(gain_out), GINIT);
        check("async_reset_state", int'(state_dbg), S_IDLE);
        check("async_reset_clip", int'(clip_flag), 0);
        tick(3);
        rst_n = 1'b1;
        tick(3);
        check("post_reset_measure", int'(state_dbg), S_MEAS);
        samp_clk = 1'b0;
        tick(1);
        s0 = step_cnt;
        repeat (WIN - 1) send_sample(100);
        check("post_reset_partial_state", int'(state_dbg), S_MEAS);
        check("post_reset_partial_gain", int'(gain_out), GINIT);
        send_sample(100);
        check("post_reset_window_gain", int'(gain_out), GINIT + 1);
        check("post_reset_window_state", int'(state_dbg), S_SET);
        check("post_reset_window_steps", step_cnt - s0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
